sram_responder: RTL and testbench

//  On-chip block-RAM memory target for the 16-bit halfword request port driven by the mmu
//  (the port otherwise served by memcache). Accepts one halfword read/write per request,

---
 rtl/sram_responder.sv | 162 ++++++++++++++++
 tb/tb_sram_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder
//   Block-RAM memory target for the 16-bit halfword request port. Each request
//   is sampled in IDLE, held for WAIT_CYCLES wait states, then completed with a
//   one-cycle data_valid strobe. Out-of-range requests complete with the same
//   timing but never touch memory, return zero on reads and set a sticky error.
//
// Ports
//   clk_i         system clock, all state on the rising edge
//   reset_i       asynchronous active-high reset
//   ce_i          chip enable from address decode; requests ignored when low
//   address_i     byte address (bit 0 ignored, halfword aligned)
//   rw_req_i      request valid, held by the requester until data_valid_o
//   rw_i          1 = write, 0 = read
//   be_i          byte lanes: be_i[1] -> [15:8] (even byte), be_i[0] -> [7:0]
//   write_data_i  write halfword, even byte in [15:8]
//   read_data_o   read halfword, held until the next completed read
//   data_valid_o  one-cycle completion strobe for reads and writes
//   range_err_o   sticky flag: an accepted request fell outside the window

module sram_responder #(
  parameter int unsigned ADDR_W      = 15,
  parameter logic [31:0] BASE        = 32'h10000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic [31:0] address_i,
  input  logic        rw_req_i,
  input  logic        rw_i,
  input  logic [1:0]  be_i,
  input  logic [15:0] write_data_i,
  output logic [15:0] read_data_o,
  output logic        data_valid_o,
  output logic        range_err_o
);

  // Size of the mapped window in bytes.
  localparam logic [31:0] SPAN = 32'd1 << (ADDR_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q;
  logic              in_range_q;
  logic              rw_q;
  logic [1:0]        be_q;
  logic [15:0]       wdata_q;
  logic [15:0]       read_data_q;
  logic              range_err_q;

  logic [15:0]       mem [2**ADDR_W];

  logic [31:0]       offset;
  logic              req_in_range;
  logic [ADDR_W-1:0] req_idx;
  logic              accept;

  logic [ADDR_W-1:0] acc_idx;
  logic              acc_in_range;
  logic              acc_rw;
  logic [1:0]        acc_be;
  logic [15:0]       acc_wdata;
  logic              commit;

  // Address decode of the live request. Addresses below BASE wrap to huge
  // offsets, but the explicit lower-bound test keeps them out of range anyway.
  assign offset       = address_i - BASE;
  assign req_in_range = (address_i >= BASE) && (offset < SPAN);
  assign req_idx      = offset[ADDR_W:1];
  assign accept       = (state_q == S_IDLE) && rw_req_i && ce_i;

  // With zero wait states the access happens on the same edge that samples the
  // request, so the live inputs are used there; otherwise the latched copy.
  assign acc_idx      = (state_q == S_IDLE) ? req_idx      : idx_q;
  assign acc_in_range = (state_q == S_IDLE) ? req_in_range : in_range_q;
  assign acc_rw       = (state_q == S_IDLE) ? rw_i         : rw_q;
  assign acc_be       = (state_q == S_IDLE) ? be_i         : be_q;
  assign acc_wdata    = (state_q == S_IDLE) ? write_data_i : wdata_q;

  // Memory is touched only on the edge that enters ACK, and never while reset
  // is held so an interrupted write can not slip through.
  assign commit = (state_d == S_ACK) && !reset_i;

  // Next-state logic: count down the wait states, abort if the requester lets
  // go of rw_req before completion, and leave ACK after exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!rw_req_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_ACK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request fields, read data and the sticky range error.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      in_range_q  <= 1'b0;
      rw_q        <= 1'b0;
      be_q        <= 2'b00;
      wdata_q     <= 16'h0;
      read_data_q <= 16'h0;
      range_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q      <= req_idx;
        in_range_q <= req_in_range;
        rw_q       <= rw_i;
        be_q       <= be_i;
        wdata_q    <= write_data_i;
        if (!req_in_range) begin
          range_err_q <= 1'b1;
        end
      end
      if ((state_d == S_ACK) && !acc_rw) begin
        read_data_q <= acc_in_range ? mem[acc_idx] : 16'h0;
      end
    end
  end

  // Byte-lane writes into the RAM array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (commit && acc_rw && acc_in_range) begin
      if (acc_be[1]) begin
        mem[acc_idx][15:8] <= acc_wdata[15:8];
      end
      if (acc_be[0]) begin
        mem[acc_idx][7:0] <= acc_wdata[7:0];
      end
    end
  end

  assign read_data_o  = read_data_q;
  assign data_valid_o = (state_q == S_ACK);
  assign range_err_o  = range_err_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
//   Drives the responder like the mmu does (rw_req held until data_valid) with
//   directed and randomized requests. Expected responses come from a halfword
//   memory model and are queued; a monitor pops them on every data_valid.
//   A second instance built with zero wait states gets a short directed run.

module tb_sram_responder;

  localparam int          ADDR_W     = 15;
  localparam logic [31:0] BASE       = 32'h10000;
  localparam int          W          = 2;
  localparam longint      SPAN_BYTES = 64'd1 << (ADDR_W + 1);

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [31:0] address;
  logic        rw_req;
  logic        rw;
  logic [1:0]  be;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        data_valid;
  logic        range_err;

  logic        ce0;
  logic [31:0] address0;
  logic        rw_req0;
  logic        rw0;
  logic [1:0]  be0;
  logic [15:0] write_data0;
  logic [15:0] read_data0;
  logic        data_valid0;
  logic        range_err0;

  sram_responder #(.ADDR_W(ADDR_W), .BASE(BASE), .WAIT_CYCLES(W)) dut (
    .clk_i(clk), .reset_i(reset), .ce_i(ce), .address_i(address),
    .rw_req_i(rw_req), .rw_i(rw), .be_i(be), .write_data_i(write_data),
    .read_data_o(read_data), .data_valid_o(data_valid), .range_err_o(range_err)
  );

  sram_responder #(.ADDR_W(ADDR_W), .BASE(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .ce_i(ce0), .address_i(address0),
    .rw_req_i(rw_req0), .rw_i(rw0), .be_i(be0), .write_data_i(write_data0),
    .read_data_o(read_data0), .data_valid_o(data_valid0), .range_err_o(range_err0)
  );

  // Free-running clock and cycle counter used for latency checks.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rdata;
    logic        rerr;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] modelMem [int];
  logic [15:0] modelRd;
  logic        modelErr;
  int          nVectors = 0;
  int          nMiscompares = 0;
  logic [15:0] prefill [16];

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour of one completed request, in byte-address terms.
  function automatic void modelRequest(input logic [31:0] addr, input logic rwv,
                                       input logic [1:0] bev, input logic [15:0] wdv);
    longint a = longint'(addr);
    int     hw;
    logic [15:0] cur;
    if (a >= longint'(BASE) && a < longint'(BASE) + SPAN_BYTES) begin
      hw = int'((a - longint'(BASE)) / 2);
      if (rwv) begin
        cur = modelMem.exists(hw) ? modelMem[hw] : 16'hxxxx;
        if (bev[1]) cur[15:8] = wdv[15:8];
        if (bev[0]) cur[7:0]  = wdv[7:0];
        modelMem[hw] = cur;
      end else begin
        modelRd = modelMem.exists(hw) ? modelMem[hw] : 16'hxxxx;
      end
    end else begin
      modelErr = 1'b1;
      if (!rwv) modelRd = 16'h0;
    end
  endfunction

  // Monitor: every data_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (data_valid) begin
      if (sbq.size() == 0) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL unexpectedValid: got data_valid with no request pending (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        checkOutput("readData", {16'h0, read_data}, {16'h0, e.rdata});
        checkOutput("rangeErr", {31'h0, range_err}, {31'h0, e.rerr});
        checkOutput("latency", cyc, e.due);
      end
    end
  end

  // Issue one request from an idle DUT (called at posedge+1). Normal requests
  // return after the ACK->IDLE edge with rw_req still high, so the caller can
  // go back-to-back. Aborted requests drop rw_req in the first wait cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic rwv,
                               input logic [1:0] bev, input logic [15:0] wdv,
                               input bit abortReq);
    exp_t e;
    bit   got;
    ce         = 1'b1;
    address    = addr;
    rw         = rwv;
    be         = bev;
    write_data = wdv;
    rw_req     = 1'b1;
    if (abortReq) begin
      @(posedge clk); #1;
      rw_req = 1'b0;
      repeat (W + 3) @(posedge clk);
      #1;
      checkOutput("abortHold", {16'h0, read_data}, {16'h0, modelRd});
    end else begin
      modelRequest(addr, rwv, bev, wdv);
      e.rdata = modelRd;
      e.rerr  = modelErr;
      e.due   = cyc + 1 + W;
      sbq.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (data_valid) got = 1'b1;
      end
      checkOutput("completion", {31'h0, got}, 32'h1);
      @(posedge clk); #1;
    end
  endtask

  task automatic idleCycles(input int n);
    rw_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int          seen;
    int          kind;
    logic [31:0] a;
    logic [15:0] wd0;

    reset = 1'b1;  ce = 1'b0; address = '0; rw_req = 1'b0; rw = 1'b0; be = 2'b00; write_data = '0;
    ce0 = 1'b1; address0 = '0; rw_req0 = 1'b0; rw0 = 1'b0; be0 = 2'b11; write_data0 = '0;
    modelRd = 16'h0;
    modelErr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReadData", {16'h0, read_data}, 32'h0);
    checkOutput("rstValid", {31'h0, data_valid}, 32'h0);
    checkOutput("rstRangeErr", {31'h0, range_err}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Known contents for the first 16 halfwords and the top of the window.
    for (int i = 0; i < 16; i++) begin
      prefill[i] = 16'($urandom);
      applyStimulus(BASE + 32'(2 * i), 1'b1, 2'b11, prefill[i], 1'b0);
    end
    applyStimulus(BASE + 32'(SPAN_BYTES) - 32'd2, 1'b1, 2'b11, 16'h7E57, 1'b0);
    applyStimulus(BASE + 32'(SPAN_BYTES) - 32'd2, 1'b0, 2'b00, 16'h0, 1'b0);
    idleCycles(2);

    // Plain write then read.
    applyStimulus(32'h10000, 1'b1, 2'b11, 16'hA55A, 1'b0);
    idleCycles(1);
    applyStimulus(32'h10000, 1'b0, 2'b11, 16'h0, 1'b0);
    checkOutput("readA55A", {16'h0, read_data}, 32'hA55A);
    idleCycles(1);

    // Byte-lane merges.
    applyStimulus(32'h10002, 1'b1, 2'b11, 16'hFFFF, 1'b0);
    applyStimulus(32'h10002, 1'b1, 2'b10, 16'h12AB, 1'b0);
    applyStimulus(32'h10002, 1'b0, 2'b00, 16'h0, 1'b0);
    checkOutput("laneHigh", {16'h0, read_data}, 32'h12FF);
    applyStimulus(32'h10002, 1'b1, 2'b01, 16'h3456, 1'b0);
    applyStimulus(32'h10002, 1'b0, 2'b11, 16'h0, 1'b0);
    checkOutput("laneLow", {16'h0, read_data}, 32'h1256);
    applyStimulus(32'h10002, 1'b1, 2'b00, 16'h9999, 1'b0);
    applyStimulus(32'h10002, 1'b0, 2'b11, 16'h0, 1'b0);
    idleCycles(1);

    // Odd byte addresses back-to-back with rw_req held.
    applyStimulus(32'h10005, 1'b0, 2'b11, 16'h0, 1'b0);
    applyStimulus(32'h10007, 1'b0, 2'b11, 16'h0, 1'b0);
    idleCycles(1);

    // Aborted write leaves memory and read_data alone.
    applyStimulus(32'h10010, 1'b1, 2'b11, 16'hBEEF, 1'b1);
    applyStimulus(32'h10010, 1'b0, 2'b11, 16'h0, 1'b0);
    idleCycles(1);

    // Out-of-range reads on both sides of the window.
    applyStimulus(BASE + 32'(SPAN_BYTES), 1'b0, 2'b11, 16'h0, 1'b0);
    applyStimulus(32'h0FFFE, 1'b0, 2'b11, 16'h0, 1'b0);
    applyStimulus(32'h10004, 1'b0, 2'b11, 16'h0, 1'b0);
    checkOutput("rangeErrSticky", {31'h0, range_err}, 32'h1);
    idleCycles(1);

    // Requests with ce low must be ignored entirely.
    ce = 1'b0; rw_req = 1'b1; rw = 1'b0; address = 32'h10000;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (data_valid) seen++;
    end
    checkOutput("ceIgnored", seen, 0);
    @(posedge clk); #1;
    idleCycles(1);

    // Reset in the middle of a write.
    ce = 1'b1; address = 32'h10012; rw = 1'b1; be = 2'b11; write_data = 16'h5555; rw_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    modelRd  = 16'h0;
    modelErr = 1'b0;
    checkOutput("midRstReadData", {16'h0, read_data}, {16'h0, modelRd});
    checkOutput("midRstValid", {31'h0, data_valid}, 32'h0);
    checkOutput("midRstRangeErr", {31'h0, range_err}, {31'h0, modelErr});
    rw_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    idleCycles(W + 2);
    applyStimulus(32'h10012, 1'b0, 2'b11, 16'h0, 1'b0);
    checkOutput("rstKeepsMem", {16'h0, read_data}, {16'h0, prefill[9]});
    idleCycles(1);

    // Randomized traffic over the prefilled halfwords plus stray addresses.
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 99));
      if (kind < 10) begin
        if ($urandom_range(0, 1) == 1)
          a = BASE - 32'(2 * $urandom_range(1, 200));
        else
          a = BASE + 32'(SPAN_BYTES) + 32'($urandom_range(0, 4000));
      end else begin
        a = BASE + 32'(2 * $urandom_range(0, 15)) + 32'($urandom_range(0, 1));
      end
      applyStimulus(a, 1'($urandom), 2'($urandom), 16'($urandom),
                    (kind >= 10 && kind < 18));
      if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 3)));
    end
    idleCycles(W + 4);
    checkOutput("sbDrained", sbq.size(), 0);

    // Zero-wait-state build: data_valid in the cycle right after sampling.
    wd0 = 16'($urandom);
    address0 = 32'h10020; rw0 = 1'b1; write_data0 = wd0; rw_req0 = 1'b1;
    #2;
    checkOutput("w0PreValid", {31'h0, data_valid0}, 32'h0);
    @(posedge clk); #1;
    checkOutput("w0WriteValid", {31'h0, data_valid0}, 32'h1);
    rw_req0 = 1'b0;
    @(posedge clk); #1;
    checkOutput("w0Idle", {31'h0, data_valid0}, 32'h0);
    rw0 = 1'b0; rw_req0 = 1'b1;
    @(posedge clk); #1;
    checkOutput("w0ReadValid", {31'h0, data_valid0}, 32'h1);
    checkOutput("w0ReadData", {16'h0, read_data0}, {16'h0, wd0});
    checkOutput("w0RangeErr", {31'h0, range_err0}, 32'h0);
    rw_req0 = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    nMiscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
